// File: rtl/acq_trigger_sequencer.sv
// rtl/acq_trigger_sequencer.sv - triggered acquisition sequencer between ADC sample stream and capture DMA
module acq_trigger_sequencer #(
  parameter int DATA_WIDTH  = 16,
  parameter int CNT_WIDTH   = 16,
  parameter int IDX_WIDTH   = 32,
  parameter int CONFIRM_LEN = 3
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  in_data_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  arm,
  input  logic                  abort,
  input  logic                  force_trig,
  input  logic [DATA_WIDTH-1:0] trigger_level,
  input  logic [CNT_WIDTH-1:0]  pre_samples,
  input  logic [CNT_WIDTH-1:0]  post_samples,
  output logic                  out_data_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic [IDX_WIDTH-1:0]  trig_index,
  output logic                  busy,
  output logic                  done,
  output logic [2:0]            state_o
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_PRE = 3'd1, S_ARMED = 3'd2, S_CONFIRM = 3'd3, S_POST = 3'd4
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CONF_CNT = CNT_WIDTH'(CONFIRM_LEN);
  localparam logic [3:0]           CONF4    = 4'(CONFIRM_LEN);

  state_t                 state, state_nxt;
  logic [IDX_WIDTH-1:0]   idx, cand_idx;
  logic [CNT_WIDTH-1:0]   pre_cnt, post_cnt, post_val, post_max;
  logic [3:0]             conf_cnt;
  logic                   below_seen, force_pend;
  logic [DATA_WIDTH-1:0]  lvl;
  logic                   above, force_now, searching;
  logic                   fwd, last, start, trig_set, trig_cand, post_set;
  logic                   to_confirm, conf_up, rearm;

  assign lvl       = (trigger_level == '0) ? DATA_WIDTH'(5) : trigger_level;
  assign above     = (in_data >= lvl);
  assign post_max  = (post_samples == '0) ? CNT_WIDTH'(1) : post_samples;
  assign searching = (state == S_ARMED) || (state == S_CONFIRM);
  assign force_now = force_trig | force_pend;

  always_ff @(posedge clk) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    fwd        = 1'b0;
    last       = 1'b0;
    start      = 1'b0;
    trig_set   = 1'b0;
    trig_cand  = 1'b0;
    post_set   = 1'b0;
    post_val   = '0;
    to_confirm = 1'b0;
    conf_up    = 1'b0;
    rearm      = 1'b0;
    if (abort) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (arm) begin
          start     = 1'b1;
          state_nxt = (pre_samples != '0) ? S_PRE : S_ARMED;
        end
        S_PRE: begin
          fwd = in_data_valid;
          if (in_data_valid && (pre_cnt + 1'b1) >= pre_samples) state_nxt = S_ARMED;
        end
        S_ARMED, S_CONFIRM: begin
          fwd = in_data_valid;
          if (in_data_valid) begin
            // Forced or single-sample-confirm trigger: this sample is post sample 1.
            if (force_now || (state == S_ARMED && above && below_seen && CONFIRM_LEN == 1)) begin
              trig_set  = 1'b1;
              post_set  = 1'b1;
              post_val  = CNT_WIDTH'(1);
              last      = (post_max == CNT_WIDTH'(1));
              state_nxt = last ? S_IDLE : S_POST;
            end else if (!above) begin
              rearm     = 1'b1;
              state_nxt = S_ARMED;
            end else if (state == S_ARMED) begin
              if (below_seen) begin
                to_confirm = 1'b1;
                state_nxt  = S_CONFIRM;
              end
            end else begin
              conf_up = 1'b1;
              if ((conf_cnt + 4'd1) == CONF4) begin
                // Confirm samples already count toward the post window.
                trig_set  = 1'b1;
                trig_cand = 1'b1;
                post_set  = 1'b1;
                post_val  = CONF_CNT;
                last      = (post_max <= CONF_CNT);
                state_nxt = last ? S_IDLE : S_POST;
              end
            end
          end
        end
        S_POST: begin
          fwd = in_data_valid;
          if (in_data_valid && (post_cnt + 1'b1) >= post_max) begin
            last      = 1'b1;
            state_nxt = S_IDLE;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy    = (state != S_IDLE);
    state_o = state;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      out_data_valid <= 1'b0;
      out_data       <= '0;
      out_last       <= 1'b0;
      done           <= 1'b0;
      trig_index     <= '0;
      idx            <= '0;
      cand_idx       <= '0;
      pre_cnt        <= '0;
      post_cnt       <= '0;
      conf_cnt       <= '0;
      below_seen     <= 1'b0;
      force_pend     <= 1'b0;
    end else begin
      out_data_valid <= fwd;
      out_data       <= in_data;
      out_last       <= last;
      done           <= last;
      if (start) begin
        idx        <= '0;
        pre_cnt    <= '0;
        conf_cnt   <= '0;
        below_seen <= 1'b0;
      end else if (fwd) begin
        idx <= idx + 1'b1;
      end
      if (fwd && state == S_PRE) pre_cnt <= pre_cnt + 1'b1;
      if (rearm) begin
        below_seen <= 1'b1;
        conf_cnt   <= '0;
      end
      if (to_confirm) begin
        cand_idx <= idx;
        conf_cnt <= 4'd1;
      end
      if (conf_up) conf_cnt <= conf_cnt + 4'd1;
      if (trig_set) trig_index <= trig_cand ? cand_idx : idx;
      if (post_set) post_cnt <= post_val;
      else if (fwd && state == S_POST) post_cnt <= post_cnt + 1'b1;
      // A force without a sample waits for the next valid sample.
      if (state_nxt == S_ARMED || state_nxt == S_CONFIRM) begin
        if (force_trig && searching && !in_data_valid) force_pend <= 1'b1;
      end else begin
        force_pend <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_acq_trigger_sequencer.sv
// tb/tb_acq_trigger_sequencer.sv - table-driven bench for acq_trigger_sequencer
module tb_acq_trigger_sequencer;

  typedef struct {
    logic        rstn, arm, abort, frc, vld;
    logic [15:0] data, lvl, pre, post;
    logic [2:0]  st;
    logic        ov, last, done;
    logic [3:0]  trig;
  } vec_t;

  logic        clk = 1'b0;
  logic        rstn = 1'b0, in_data_valid = 1'b0, arm = 1'b0, abort = 1'b0, force_trig = 1'b0;
  logic [15:0] in_data = '0, trigger_level = '0, pre_samples = '0, post_samples = '0;
  logic        out_data_valid, out_last, busy, done;
  logic [15:0] out_data;
  logic [3:0]  trig_index;
  logic [2:0]  state_o;

  vec_t        vq[$];
  logic [15:0] cur_lvl, cur_pre, cur_post;
  logic [3:0]  cur_trig;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  acq_trigger_sequencer #(.DATA_WIDTH(16), .CNT_WIDTH(16), .IDX_WIDTH(4), .CONFIRM_LEN(3)) dut (
    .clk(clk), .rstn(rstn), .in_data_valid(in_data_valid), .in_data(in_data),
    .arm(arm), .abort(abort), .force_trig(force_trig), .trigger_level(trigger_level),
    .pre_samples(pre_samples), .post_samples(post_samples),
    .out_data_valid(out_data_valid), .out_data(out_data), .out_last(out_last),
    .trig_index(trig_index), .busy(busy), .done(done), .state_o(state_o)
  );

  task automatic push(input logic r, a, ab, f, v, input logic [15:0] d,
                      input logic [2:0] st, input logic ov, input logic ls);
    vec_t e;
    e.rstn = r; e.arm = a; e.abort = ab; e.frc = f; e.vld = v; e.data = d;
    e.lvl = cur_lvl; e.pre = cur_pre; e.post = cur_post;
    e.st = st; e.ov = ov; e.last = ls; e.done = ls; e.trig = cur_trig;
    vq.push_back(e);
  endtask

  task automatic chk(input string nm, input int i, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s vec %0d: got %0h expected %0h", nm, i, got, want);
    end
  endtask

  initial begin
    logic [15:0] g2[7]  = '{50, 150, 150, 50, 150, 150, 150};
    logic [2:0]  s2[7]  = '{2, 3, 3, 2, 3, 3, 4};
    logic [15:0] g3[6]  = '{200, 200, 50, 200, 200, 200};
    logic [2:0]  s3[6]  = '{2, 2, 2, 3, 3, 0};
    logic [15:0] g4[5]  = '{0, 4, 5, 5, 5};
    logic [2:0]  s4[5]  = '{2, 2, 3, 3, 0};

    // reset
    cur_lvl = 100; cur_pre = 4; cur_post = 8; cur_trig = 0;
    push(0, 0, 0, 0, 0, 0, 0, 0, 0);
    push(0, 0, 0, 0, 1, 7, 0, 0, 0);
    // ramp: 4 pre samples, trigger at 100 (idx 10), 8 post samples; arm at k=5 is ignored
    push(1, 1, 0, 0, 0, 0, 1, 0, 0);
    for (int k = 0; k <= 18; k++) begin
      logic [2:0] st;
      st = (k < 3) ? 3'd1 : (k <= 9) ? 3'd2 : (k <= 11) ? 3'd3 : (k <= 16) ? 3'd4 : 3'd0;
      if (k == 12) cur_trig = 10;
      push(1, k == 5, 0, 0, 1, 16'(10 * k), st, k <= 17, k == 17);
    end
    // glitch during confirm, trigger index held across arm until retrigger
    cur_pre = 0;
    push(1, 1, 0, 0, 0, 0, 2, 0, 0);
    for (int i = 0; i < 7; i++) begin
      if (i == 6) cur_trig = 4;
      push(1, 0, 0, 0, 1, g2[i], s2[i], 1, 0);
    end
    for (int i = 0; i < 5; i++) push(1, 0, 0, 0, 1, 150, (i == 4) ? 3'd0 : 3'd4, 1, i == 4);
    // already above at arm; post 2 ends on the confirming sample
    cur_post = 2;
    push(1, 1, 0, 0, 0, 0, 2, 0, 0);
    for (int i = 0; i < 6; i++) begin
      if (i == 5) cur_trig = 3;
      push(1, 0, 0, 0, 1, g3[i], s3[i], 1, i == 5);
    end
    // level 0 acts as 5
    cur_lvl = 0; cur_post = 3;
    push(1, 1, 0, 0, 0, 0, 2, 0, 0);
    for (int i = 0; i < 5; i++) begin
      if (i == 4) cur_trig = 2;
      push(1, 0, 0, 0, 1, g4[i], s4[i], 1, i == 4);
    end
    // force without a sample, then next sample triggers; post 1
    cur_lvl = 100; cur_post = 1;
    push(1, 1, 0, 0, 0, 0, 2, 0, 0);
    push(1, 0, 0, 0, 1, 0, 2, 1, 0);
    push(1, 0, 0, 0, 1, 0, 2, 1, 0);
    push(1, 0, 0, 1, 0, 0, 2, 0, 0);
    cur_trig = 2;
    push(1, 0, 0, 0, 1, 0, 0, 1, 1);
    // force with a sample in the same cycle; post 2
    cur_post = 2;
    push(1, 1, 0, 0, 0, 0, 2, 0, 0);
    push(1, 0, 0, 0, 1, 0, 2, 1, 0);
    cur_trig = 1;
    push(1, 0, 0, 1, 1, 0, 4, 1, 0);
    push(1, 0, 0, 0, 1, 0, 0, 1, 1);
    // abort in POST, then arm+abort together
    cur_post = 8;
    push(1, 1, 0, 0, 0, 0, 2, 0, 0);
    push(1, 0, 0, 0, 1, 50, 2, 1, 0);
    push(1, 0, 0, 0, 1, 150, 3, 1, 0);
    push(1, 0, 0, 0, 1, 150, 3, 1, 0);
    cur_trig = 1;
    push(1, 0, 0, 0, 1, 150, 4, 1, 0);
    push(1, 0, 0, 0, 1, 150, 4, 1, 0);
    push(1, 0, 1, 0, 1, 150, 0, 0, 0);
    push(1, 0, 0, 0, 1, 150, 0, 0, 0);
    push(1, 1, 1, 0, 0, 0, 0, 0, 0);
    // reset in CONFIRM
    push(1, 1, 0, 0, 0, 0, 2, 0, 0);
    push(1, 0, 0, 0, 1, 50, 2, 1, 0);
    push(1, 0, 0, 0, 1, 150, 3, 1, 0);
    cur_trig = 0;
    push(0, 0, 0, 0, 1, 150, 0, 0, 0);
    push(1, 0, 0, 0, 0, 0, 0, 0, 0);
    // re-arm works; index wraps at 16
    cur_post = 1;
    push(1, 1, 0, 0, 0, 0, 2, 0, 0);
    for (int i = 0; i < 20; i++) push(1, 0, 0, 0, 1, 0, 2, 1, 0);
    cur_trig = 4;
    push(1, 0, 0, 1, 1, 0, 0, 1, 1);

    for (int i = 0; i < vq.size(); i++) begin
      rstn          = vq[i].rstn;
      arm           = vq[i].arm;
      abort         = vq[i].abort;
      force_trig    = vq[i].frc;
      in_data_valid = vq[i].vld;
      in_data       = vq[i].data;
      trigger_level = vq[i].lvl;
      pre_samples   = vq[i].pre;
      post_samples  = vq[i].post;
      @(posedge clk);
      #1;
      chk("state", i, 32'(state_o), 32'(vq[i].st));
      chk("busy", i, 32'(busy), 32'(vq[i].st != 3'd0));
      chk("out_valid", i, 32'(out_data_valid), 32'(vq[i].ov));
      chk("out_last", i, 32'(out_last), 32'(vq[i].last));
      chk("done", i, 32'(done), 32'(vq[i].done));
      chk("trig_index", i, 32'(trig_index), 32'(vq[i].trig));
      if (vq[i].ov) chk("out_data", i, 32'(out_data), 32'(vq[i].data));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
